// File: rtl/cnt_day_gen.sv
// rtl/cnt_day_gen.sv - day-of-month counter with leap-year aware month length
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_day   in   one-cycle day-advance strobe
//   month      in   [3:0] current month, 1..12
//   year       in   [YEAR_W-1:0] current year, unsigned
//   load_en    in   one-cycle load strobe, wins over tick_day
//   load_day   in   [4:0] day value to load, clamped to 1..dim
//   day        out  [4:0] current day of month, registered
//   inc_month  out  registered one-cycle pulse on month rollover
//   dim        out  [4:0] days in current month, combinational

module cnt_day_gen #(
    parameter int YEAR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_day,
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    input  logic              load_en,
    input  logic [4:0]        load_day,
    output logic [4:0]        day,
    output logic              inc_month,
    output logic [4:0]        dim
);

    // The year is widened so the constant 400 always fits, even for small YEAR_W.
    localparam int YW = (YEAR_W > 9) ? YEAR_W : 9;

    logic [YW-1:0] year_ext;
    logic          div_4;
    logic          div_100;
    logic          div_400;
    logic          leap;

    assign year_ext = YW'(year);
    assign div_4    = (year_ext[1:0] == 2'b00);
    assign div_100  = ((year_ext % YW'(100)) == '0);
    assign div_400  = ((year_ext % YW'(400)) == '0);
    // Year 0 is divisible by 400, so it is leap without a special case.
    assign leap     = (div_4 && !div_100) || div_400;

    always_comb begin
        dim = 5'd31;
        unique case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = leap ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
    end

    logic [4:0] day_d;
    logic [4:0] day_q;
    logic       inc_month_d;
    logic       inc_month_q;

    always_comb begin
        day_d       = day_q;
        inc_month_d = 1'b0;
        if (load_en) begin
            // Load discards any simultaneous tick, so no rollover pulse here.
            if (load_day == 5'd0) begin
                day_d = 5'd1;
            end else if (load_day > dim) begin
                day_d = dim;
            end else begin
                day_d = load_day;
            end
        end else if (tick_day) begin
            // >= rather than == so an out-of-range day (month changed under
            // us) wraps cleanly instead of counting past the month end.
            if (day_q >= dim) begin
                day_d       = 5'd1;
                inc_month_d = 1'b1;
            end else begin
                day_d = day_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q       <= 5'd1;
            inc_month_q <= 1'b0;
        end else begin
            day_q       <= day_d;
            inc_month_q <= inc_month_d;
        end
    end

    assign day       = day_q;
    assign inc_month = inc_month_q;

endmodule

// File: tb/tb_cnt_day_gen.sv
// tb/tb_cnt_day_gen.sv - directed self-checking bench for cnt_day_gen

module tb_cnt_day_gen;

    logic        clk;
    logic        rst_n;
    logic        tick_day;
    logic [3:0]  month;
    logic [11:0] year;
    logic        load_en;
    logic [4:0]  load_day;
    logic [4:0]  day;
    logic        inc_month;
    logic [4:0]  dim;

    int n_checks;
    int n_pass;
    int inc_seen;

    cnt_day_gen #(.YEAR_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_day  (tick_day),
        .month     (month),
        .year      (year),
        .load_en   (load_en),
        .load_day  (load_day),
        .day       (day),
        .inc_month (inc_month),
        .dim       (dim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Apply strobes for one rising edge, then sample 1 time unit after it.
    task automatic cycle(input logic t, input logic l, input logic [4:0] ld);
        tick_day = t;
        load_en  = l;
        load_day = ld;
        @(posedge clk);
        #1;
        tick_day = 1'b0;
        load_en  = 1'b0;
        load_day = 5'd0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        inc_seen = 0;
        rst_n    = 1'b0;
        tick_day = 1'b0;
        load_en  = 1'b0;
        load_day = 5'd0;
        month    = 4'd1;
        year     = 12'd2024;

        repeat (2) @(posedge clk);
        #1;
        check("rst_day", day, 5'd1);
        check("rst_inc", inc_month, 1'b0);
        check("dim_jan", dim, 5'd31);

        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 5'd0);
        check("release_day", day, 5'd1);
        check("release_inc", inc_month, 1'b0);

        // January 2024: 30 ticks reach 31 with no pulse, the 31st wraps.
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 1'b0, 5'd0);
            if (inc_month) inc_seen++;
        end
        check("jan_day31", day, 5'd31);
        check("jan_no_pulse", inc_seen, 0);
        cycle(1'b1, 1'b0, 5'd0);
        check("jan_wrap_day", day, 5'd1);
        check("jan_wrap_inc", inc_month, 1'b1);
        cycle(1'b0, 1'b0, 5'd0);
        check("jan_pulse_end", inc_month, 1'b0);
        check("jan_hold_day", day, 5'd1);

        // February, leap and non-leap.
        month = 4'd2;
        year  = 12'd2024;
        #1;
        check("dim_feb2024", dim, 5'd29);
        cycle(1'b0, 1'b1, 5'd28);
        check("feb_load28", day, 5'd28);
        cycle(1'b1, 1'b0, 5'd0);
        check("feb24_day29", day, 5'd29);
        check("feb24_no_inc", inc_month, 1'b0);
        cycle(1'b1, 1'b0, 5'd0);
        check("feb24_wrap_day", day, 5'd1);
        check("feb24_wrap_inc", inc_month, 1'b1);
        year = 12'd2023;
        cycle(1'b0, 1'b1, 5'd28);
        check("feb23_load_inc", inc_month, 1'b0);
        cycle(1'b1, 1'b0, 5'd0);
        check("feb23_wrap_day", day, 5'd1);
        check("feb23_wrap_inc", inc_month, 1'b1);

        // Month-length table corners.
        year = 12'd1900; #1; check("dim_1900", dim, 5'd28);
        year = 12'd2000; #1; check("dim_2000", dim, 5'd29);
        year = 12'd0;    #1; check("dim_year0", dim, 5'd29);
        year = 12'd2100; #1; check("dim_2100", dim, 5'd28);
        month = 4'd4;    #1; check("dim_apr", dim, 5'd30);
        month = 4'd11;   #1; check("dim_nov", dim, 5'd30);
        month = 4'd8;    #1; check("dim_aug", dim, 5'd31);
        month = 4'd13;   #1; check("dim_m13", dim, 5'd31);
        month = 4'd0;    #1; check("dim_m0", dim, 5'd31);

        // Load clamping and load priority in April.
        month = 4'd4;
        year  = 12'd2024;
        cycle(1'b0, 1'b1, 5'd31);
        check("load31_clamp", day, 5'd30);
        cycle(1'b0, 1'b1, 5'd0);
        check("load0_clamp", day, 5'd1);
        cycle(1'b0, 1'b1, 5'd30);
        check("load30", day, 5'd30);
        cycle(1'b1, 1'b1, 5'd12);
        check("prio_day", day, 5'd12);
        check("prio_inc", inc_month, 1'b0);
        cycle(1'b1, 1'b0, 5'd0);
        check("apr_day13", day, 5'd13);

        // Out-of-range recovery: day 31 then month switched to April.
        month = 4'd1;
        cycle(1'b0, 1'b1, 5'd31);
        check("oor_load", day, 5'd31);
        month = 4'd4;
        cycle(1'b1, 1'b0, 5'd0);
        check("oor_day", day, 5'd1);
        check("oor_inc", inc_month, 1'b1);

        // Asynchronous reset during the pulse cycle.
        month = 4'd1;
        cycle(1'b0, 1'b1, 5'd31);
        cycle(1'b1, 1'b0, 5'd0);
        check("arst_pre_inc", inc_month, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_inc", inc_month, 1'b0);
        check("arst_day", day, 5'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 5'd0);
        check("arst_rel_day", day, 5'd1);
        check("arst_rel_inc", inc_month, 1'b0);
        cycle(1'b1, 1'b0, 5'd0);
        check("arst_tick_day", day, 5'd2);
        check("arst_tick_inc", inc_month, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnt_day_gen.md
CNT_DAY_GEN -- requirements
Module: cnt_day_gen

Interface
REQ-001 Parameter: YEAR_W, default 12, width of the year input.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 tick_day  input  1  one-cycle day-advance strobe, sampled on clk.
REQ-005 month  input  4  current month (1..12), driven by the downstream month counter.
REQ-006 year  input  YEAR_W  current year, unsigned, used for leap-year rule.
REQ-007 load_en  input  1  one-cycle load strobe for day value.
REQ-008 load_day  input  5  day value to load.
REQ-009 day  output  5  current day of month, registered.
REQ-010 inc_month  output  1  registered one-cycle pulse to the month counter on month rollover.
REQ-011 dim  output  5  days in current month, combinational from month/year.

Function
REQ-012 dim SHALL be: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for month 2 in a leap year; 28 for month 2 otherwise.
REQ-013 Leap year SHALL be: year divisible by 4 and not by 100, or divisible by 400; year 0 counts as leap.
REQ-014 Invalid month (0, 13-15) SHALL yield dim = 31.
REQ-015 On tick_day with load_en low and day < dim: day <= day + 1, inc_month <= 0 next cycle.
REQ-016 On tick_day with load_en low and day >= dim: day <= 1, inc_month <= 1 for exactly the next cycle (wrap condition >= also recovers from out-of-range day).
REQ-017 inc_month SHALL be 0 in every cycle not immediately following a wrapping tick; it never stays high two consecutive cycles unless two consecutive wrapping ticks occur.
REQ-018 On load_en: day <= load_day clamped: 0 -> 1; value > dim -> dim; inc_month <= 0.
REQ-019 load_en SHALL have priority over tick_day; a simultaneous tick is discarded and produces no inc_month.
REQ-020 With neither tick_day nor load_en: day holds, inc_month <= 0.
REQ-021 month/year change in the same cycle as a tick SHALL be ignored for that tick; dim is evaluated from the month/year values present at the tick edge.
REQ-022 Latency: day and inc_month update on the rising edge that samples tick_day; both become visible together one cycle after the strobe.
REQ-023 No arithmetic overflow: day + 1 computed only when day < dim <= 31, so 5 bits suffice.

Reset
REQ-024 While rst_n = 0: day = 1, inc_month = 0, independent of clk.
REQ-025 Reset asserted mid-operation (including the cycle inc_month is high) SHALL clear immediately; first tick after release advances day 1 -> 2.
REQ-026 rst_n deassertion SHALL not by itself generate inc_month or change day.

Verification
REQ-027 Reset, month=1, year=2024, 30 ticks -> day=31, inc_month never high; 31st tick -> day=1, inc_month=1 for one cycle.
REQ-028 month=2, year=2024, load 28, tick -> day=29, no pulse; tick -> day=1, inc_month pulse. Repeat year=2023: load 28, tick -> day=1, pulse.
REQ-029 month=2, year=1900 -> dim=28; year=2000 -> dim=29; month=4 -> dim=30; month=13 -> dim=31.
REQ-030 month=4, load_day=31 -> day=30; load_day=0 -> day=1; load_en and tick_day together with day=30 -> day=load value, no inc_month.
REQ-031 day=31 in month=1, then month driven to 4 before tick -> tick gives day=1 with inc_month pulse (out-of-range recovery).
REQ-032 rst_n pulled low asynchronously in the cycle inc_month=1 -> inc_month=0 and day=1 before the next clk edge.
